mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_div_iter.sv | 44 ++++
 rtl/mdu_seq.sv | 178 +++++++++++++++++
 tb/tb_mdu_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants, op codes and FSM states for the sequential mul/div unit.
// Build option: MDU_FAST_MUL_EN selects the single-cycle multiplier.
package mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_DIV_BUSY,
        S_DONE
    } mdu_state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT    = '1;
    localparam logic [XLEN-1:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [XLEN-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_REM      = '0;

    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring shift-subtract divider on unsigned magnitudes, one bit per step.
// Outputs are the post-step values so the last step's result is usable at once.
module mdu_div_iter
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot_nxt,
    output logic [XLEN-1:0] o_rem_nxt
);

    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] r_d;
    logic [XLEN:0]   w_sh;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    assign w_sh       = {r_r, r_q[XLEN-1]};
    assign w_ge       = w_sh >= {1'b0, r_d};
    assign w_diff     = w_sh[XLEN-1:0] - r_d;
    assign o_rem_nxt  = w_ge ? w_diff : w_sh[XLEN-1:0];
    assign o_quot_nxt = {r_q[XLEN-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            r_r <= '0;
            r_d <= '0;
        end else if (i_start) begin
            r_q <= i_dividend;
            r_r <= '0;
            r_d <= i_divisor;
        end else if (i_step) begin
            r_q <= o_quot_nxt;
            r_r <= o_rem_nxt;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: FSM, sign fix-up and multiplier.
// Define MDU_FAST_MUL_EN for a combinational 1-cycle multiplier.
module mdu_seq
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_e      r_state;
    logic [4:0]      r_cnt;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_is_div;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN-1:0] w_qn;
    logic [XLEN-1:0] w_rn;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_busy_res;

    assign w_accept = (r_state == S_IDLE) & req_valid & ~flush;
    assign w_is_div = req_op[2];
    assign w_a_neg  = op_signed_a(req_op) & rs1[XLEN-1];
    assign w_b_neg  = op_signed_b(req_op) & rs2[XLEN-1];
    assign w_a_mag  = w_a_neg ? -rs1 : rs1;
    assign w_b_mag  = w_b_neg ? -rs2 : rs2;
    assign w_div0   = rs2 == '0;
    assign w_ovf    = ~req_op[0] & (rs1 == OVF_DIVIDEND) &
                      (rs2 == OVF_DIVISOR);

    // op[1] separates REM/REMU from DIV/DIVU
    assign w_spec_res = w_div0 ? (req_op[1] ? rs1 : DIV0_QUOT)
                               : (req_op[1] ? OVF_REM : OVF_DIVIDEND);

    mdu_div_iter u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_accept & w_is_div),
        .i_step     (r_state == S_DIV_BUSY),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quot_nxt (w_qn),
        .o_rem_nxt  (w_rn)
    );

    assign w_quot = r_neg_q ? -w_qn : w_qn;
    assign w_rem  = r_neg_r ? -w_rn : w_rn;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_ea;
    logic [2*XLEN-1:0] w_eb;
    logic [2*XLEN-1:0] w_full;
    logic [XLEN-1:0]   w_fast_res;

    assign w_ea       = {{XLEN{w_a_neg}}, rs1};
    assign w_eb       = {{XLEN{w_b_neg}}, rs2};
    assign w_full     = w_ea * w_eb;
    assign w_fast_res = (req_op == OP_MUL) ? w_full[XLEN-1:0]
                                           : w_full[2*XLEN-1:XLEN];
`else
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic              r_mul_lo;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    // shift-add: high half accumulates, multiplier drains from the low half
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                       (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    assign w_prod    = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_mul_res = r_mul_lo ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mul_lo <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_acc    <= {{XLEN{1'b0}}, w_b_mag};
            r_mul_lo <= req_op == OP_MUL;
        end else if (r_state == S_MUL_BUSY) begin
            r_acc    <= w_acc_nxt;
        end
    end
`endif

    always_comb begin
        w_busy_res = r_sel_rem ? w_rem : w_quot;
`ifndef MDU_FAST_MUL_EN
        if (r_state == S_MUL_BUSY) w_busy_res = w_mul_res;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (req_valid) begin
                    r_sel_rem <= req_op[1];
                    r_neg_q   <= w_a_neg ^ w_b_neg;
                    r_neg_r   <= w_a_neg;
                    r_cnt     <= '0;
                    if (w_is_div && (w_div0 || w_ovf)) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_spec_res;
                    end else if (w_is_div) begin
                        r_state <= S_DIV_BUSY;
                    end
`ifdef MDU_FAST_MUL_EN
                    else begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_fast_res;
                    end
`else
                    else begin
                        r_state <= S_MUL_BUSY;
                    end
`endif
                end
                S_MUL_BUSY, S_DIV_BUSY: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_busy_res;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stall  = req_valid & ~r_done;
    assign busy   = r_state != S_IDLE;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed table, random ops, flush and reset.
// Latency expectations follow MDU_FAST_MUL_EN when it is defined.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_mis = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mdu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit sgn;
        if (!op[2]) return MUL_LAT;
        sgn = (op == 3'b100) || (op == 3'b110);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called #1 after a posedge while the DUT is idle; cycle 0 is that cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit stall_ok);
        int cyc;
        bit got;
        req_valid = 1'b1;
        req_op    = op;
        rs1       = a;
        rs2       = b;
        res       = 'x;
        lat       = -1;
        stall_ok  = 1'b1;
        got       = 1'b0;
        cyc       = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = cyc;
                res = result;
                if (stall) stall_ok = 1'b0;
            end else if (!stall) begin
                stall_ok = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!got) cyc++;
        end
        req_valid = 1'b0;
    endtask

    task automatic apply(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int lat;
        bit sok;
        run_op(op, a, b, res, lat, sok);
        check({name, ".res"}, res, exp_res);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".stall"}, 32'(sok), 32'd1);
        @(negedge clk);
        check({name, ".hold"}, result, exp_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw_done;
        logic [2:0]  op;
        logic [31:0] a, b;

        tbl.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 33});
        tbl.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 33});
        tbl.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
        tbl.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
        tbl.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        tbl.push_back('{3'b110, 32'd5, 32'd0, 32'd5, 1});
        tbl.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
                        32'h8000_0000, 1});
        tbl.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
        tbl.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33});
        tbl.push_back('{3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 1});
        tbl.push_back('{3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, MUL_LAT});
        tbl.push_back('{3'b000, 32'h8000_0000, 32'd2, 32'd0, MUL_LAT});
        tbl.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFE, MUL_LAT});
        tbl.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                        32'hFFFF_FFFF, MUL_LAT});
        tbl.push_back('{3'b000, 32'd123, 32'hFFFF_FFFE, 32'hFFFF_FF0A, MUL_LAT});

        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].res, tbl[i].lat);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            apply($sformatf("rnd%0d", i), op, a, b,
                  ref_res(op, a, b), ref_lat(op, a, b));
        end

        // flush at iteration 10 of a DIVU
        req_valid = 1'b1;
        req_op    = 3'b101;
        rs1       = 32'd1000;
        rs2       = 32'd3;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        check("flush.busy_before", 32'(busy), 32'd1);
        flush     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush.busy_after", 32'(busy), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("flush.no_done", 32'(saw_done), 32'd0);
        @(posedge clk);
        #1;
        apply("flush.next", 3'b101, 32'd9, 32'd3, 32'd3, 33);

        // async reset at iteration 5
        req_valid = 1'b1;
        req_op    = 3'b101;
        rs1       = 32'd50000;
        rs2       = 32'd7;
        @(posedge clk);
        #1;
        repeat (5) @(posedge clk);
        #1;
        check("arst.busy_before", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check("arst.result", result, 32'd0);
        check("arst.stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("arst.no_done", 32'(saw_done), 32'd0);
        @(posedge clk);
        #1;
        apply("arst.mulhu", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678,
              ref_res(3'b011, 32'hDEAD_BEEF, 32'h1234_5678), MUL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
